// File: rtl/spu_ins_buffer_if.sv
// Fetch/decode-facing signal bundle for the SPU instruction buffer.
// master = fetch+decode side, slave = the buffer.
interface spu_ins_buffer_if #(
    parameter int DEPTH  = 8,
    parameter int INS_WD = 32,
    parameter int PC_WD  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid0;
    logic              in_valid1;
    logic [INS_WD-1:0] in_ins0;
    logic [INS_WD-1:0] in_ins1;
    logic [PC_WD-1:0]  in_pc;
    logic              in_ready;
    logic              flush;
    logic [INS_WD-1:0] eins1;
    logic [INS_WD-1:0] eins2;
    logic [PC_WD-1:0]  pc_out;
    logic [1:0]        out_cnt;
    logic [1:0]        issue_cnt;
    logic [CW-1:0]     count;
    logic              buf_err;

    modport master (
        output in_valid0, in_valid1, in_ins0, in_ins1, in_pc, flush, issue_cnt,
        input  in_ready, eins1, eins2, pc_out, out_cnt, count, buf_err
    );

    modport slave (
        input  in_valid0, in_valid1, in_ins0, in_ins1, in_pc, flush, issue_cnt,
        output in_ready, eins1, eins2, pc_out, out_cnt, count, buf_err
    );
endinterface

// File: rtl/spu_ins_buffer.sv
// Two-wide circular instruction buffer between SPU fetch and decode.
// Optional sticky protocol-error flag: define SPU_INS_BUF_ERR_CHK_EN.
module spu_ins_buffer #(
    parameter int DEPTH  = 8,
    parameter int INS_WD = 32,
    parameter int PC_WD  = 32
) (
    input  logic             clk,
    input  logic             rst,
    spu_ins_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INS_WD-1:0] r_ins [DEPTH];
    logic [PC_WD-1:0]  r_pc  [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic              w_in_ready;
    logic [1:0]        w_out_cnt;
    logic [1:0]        w_pop_n;
    logic [1:0]        w_push_n;
    logic [AW-1:0]     w_head_p1;
    logic [AW-1:0]     w_tail_p1;

    // in_ready looks only at registered occupancy; a same-cycle pop cannot raise it
    assign w_in_ready = (r_count <= CW'(DEPTH - 2));
    assign w_out_cnt  = (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];
    assign w_head_p1  = r_head + AW'(1);
    assign w_tail_p1  = r_tail + AW'(1);

    always_comb begin
        w_pop_n  = (bus.issue_cnt > w_out_cnt) ? w_out_cnt : bus.issue_cnt;
        w_push_n = 2'd0;
        if (bus.in_valid0 && w_in_ready)
            w_push_n = bus.in_valid1 ? 2'd2 : 2'd1;
        if (bus.flush) begin
            w_pop_n  = 2'd0;
            w_push_n = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop_n);
            r_tail  <= r_tail + AW'(w_push_n);
            r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
        end
    end

    // Storage needs no reset: visibility is gated by r_count
    always_ff @(posedge clk) begin
        if (w_push_n != 2'd0) begin
            r_ins[r_tail] <= bus.in_ins0;
            r_pc[r_tail]  <= bus.in_pc;
        end
        if (w_push_n == 2'd2) begin
            r_ins[w_tail_p1] <= bus.in_ins1;
            r_pc[w_tail_p1]  <= bus.in_pc + PC_WD'(4);
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.out_cnt  = w_out_cnt;
    assign bus.count    = r_count;
    assign bus.eins1    = (r_count != '0)       ? r_ins[r_head]    : '0;
    assign bus.pc_out   = (r_count != '0)       ? r_pc[r_head]     : '0;
    assign bus.eins2    = (r_count >= CW'(2))   ? r_ins[w_head_p1] : '0;

`ifdef SPU_INS_BUF_ERR_CHK_EN
    logic r_buf_err;
    logic w_err;

    assign w_err = (bus.in_valid0 && !w_in_ready)
                 || (bus.issue_cnt > w_out_cnt)
                 || (bus.in_valid1 && !bus.in_valid0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_buf_err <= 1'b0;
        else if (w_err)
            r_buf_err <= 1'b1;
    end

    assign bus.buf_err = r_buf_err;
`else
    assign bus.buf_err = 1'b0;
`endif
endmodule

// File: tb/tb_spu_ins_buffer.sv
// Self-checking bench for spu_ins_buffer: directed vector table, async reset
// sequence and randomized traffic against a queue-based reference model.
module tb_spu_ins_buffer;
    localparam int DEPTH  = 8;
    localparam int INS_WD = 32;
    localparam int PC_WD  = 32;

    logic clk;
    logic rst;

    spu_ins_buffer_if #(.DEPTH(DEPTH), .INS_WD(INS_WD), .PC_WD(PC_WD)) bus ();

    spu_ins_buffer #(.DEPTH(DEPTH), .INS_WD(INS_WD), .PC_WD(PC_WD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    logic m_err = 1'b0;

    typedef struct {
        logic        v0, v1;
        logic [31:0] i0, i1, pc;
        logic        fl;
        logic [1:0]  iss;
        int          e_cnt, e_oc;
        logic [31:0] e1, e2, epc;
        logic        erdy;
    } vec_t;

    function automatic vec_t mk(logic v0, logic v1, logic [31:0] i0, logic [31:0] i1,
                                logic [31:0] pc, logic fl, logic [1:0] iss,
                                int e_cnt, int e_oc, logic [31:0] e1, logic [31:0] e2,
                                logic [31:0] epc, logic erdy);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.i0 = i0; v.i1 = i1; v.pc = pc; v.fl = fl; v.iss = iss;
        v.e_cnt = e_cnt; v.e_oc = e_oc; v.e1 = e1; v.e2 = e2; v.epc = epc; v.erdy = erdy;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: the buffer is just an ordered queue of {ins, pc}
    task automatic model_step(logic v0, logic v1, logic [31:0] i0, logic [31:0] i1,
                              logic [31:0] pc, logic fl, logic [1:0] iss);
        int sz = q.size();
        int oc = (sz > 2) ? 2 : sz;
        int pop;
        bit can_push = (sz <= DEPTH - 2);
`ifdef SPU_INS_BUF_ERR_CHK_EN
        if ((v0 && !can_push) || (int'(iss) > oc) || (v1 && !v0)) m_err = 1'b1;
`endif
        if (fl) begin
            q.delete();
        end else begin
            pop = (int'(iss) > oc) ? oc : int'(iss);
            for (int k = 0; k < pop; k++) void'(q.pop_front());
            if (v0 && can_push) begin
                q.push_back('{ins: i0, pc: pc});
                if (v1) q.push_back('{ins: i1, pc: pc + 32'd4});
            end
        end
    endtask

    task automatic check_model(string tag);
        int sz = q.size();
        chk({tag, ".count"},    64'(bus.count),    64'(sz));
        chk({tag, ".out_cnt"},  64'(bus.out_cnt),  64'((sz > 2) ? 2 : sz));
        chk({tag, ".eins1"},    64'(bus.eins1),    64'((sz >= 1) ? q[0].ins : 32'd0));
        chk({tag, ".pc_out"},   64'(bus.pc_out),   64'((sz >= 1) ? q[0].pc  : 32'd0));
        chk({tag, ".eins2"},    64'(bus.eins2),    64'((sz >= 2) ? q[1].ins : 32'd0));
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(sz <= DEPTH - 2));
        chk({tag, ".buf_err"},  64'(bus.buf_err),  64'(m_err));
    endtask

    // Called at a falling edge; drives inputs, crosses one rising edge, returns at next falling edge
    task automatic step(logic v0, logic v1, logic [31:0] i0, logic [31:0] i1,
                        logic [31:0] pc, logic fl, logic [1:0] iss, string tag);
        bus.in_valid0 = v0;  bus.in_valid1 = v1;
        bus.in_ins0   = i0;  bus.in_ins1   = i1;
        bus.in_pc     = pc;  bus.flush     = fl;
        bus.issue_cnt = iss;
        @(posedge clk);
        model_step(v0, v1, i0, i1, pc, fl, iss);
        @(negedge clk);
        check_model(tag);
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = mk(1,1,32'h40000001,32'h40000002,32'h100, 0,0, 2,2,32'h40000001,32'h40000002,32'h100,1);
        tbl[1]  = mk(0,0,0,0,0,                           0,1, 1,1,32'h40000002,32'h0,32'h104,1);
        tbl[2]  = mk(0,0,0,0,0,                           0,1, 0,0,0,0,0,1);
        tbl[3]  = mk(0,0,0,0,0,                           0,2, 0,0,0,0,0,1);
        tbl[4]  = mk(1,1,32'h50000000,32'h50000001,32'h1000,0,0, 2,2,32'h50000000,32'h50000001,32'h1000,1);
        tbl[5]  = mk(1,1,32'h50000002,32'h50000003,32'h1008,0,0, 4,2,32'h50000000,32'h50000001,32'h1000,1);
        tbl[6]  = mk(1,1,32'h50000004,32'h50000005,32'h1010,0,0, 6,2,32'h50000000,32'h50000001,32'h1000,1);
        tbl[7]  = mk(1,1,32'h50000006,32'h50000007,32'h1018,0,0, 8,2,32'h50000000,32'h50000001,32'h1000,0);
        tbl[8]  = mk(1,1,32'h60000000,32'h60000001,32'h2000,0,0, 8,2,32'h50000000,32'h50000001,32'h1000,0);
        tbl[9]  = mk(0,0,0,0,0,                           0,2, 6,2,32'h50000002,32'h50000003,32'h1008,1);
        tbl[10] = mk(1,1,32'h70000000,32'h70000001,32'h3000,0,0, 8,2,32'h50000002,32'h50000003,32'h1008,0);
        tbl[11] = mk(0,0,0,0,0,                           0,2, 6,2,32'h50000004,32'h50000005,32'h1010,1);
        tbl[12] = mk(1,1,32'h80000000,32'h80000001,32'h4000,0,1, 7,2,32'h50000005,32'h50000006,32'h1014,0);
        tbl[13] = mk(0,0,0,0,0,                           0,2, 5,2,32'h50000007,32'h70000000,32'h101C,1);
        tbl[14] = mk(1,1,32'h90000000,32'h90000001,32'h2222,1,2, 0,0,0,0,0,1);
        tbl[15] = mk(1,0,32'hA0000000,32'hA0000001,32'h200, 0,0, 1,1,32'hA0000000,32'h0,32'h200,1);
        tbl[16] = mk(0,0,0,0,0,                           0,3, 0,0,0,0,0,1);

        rst = 1'b0;
        bus.in_valid0 = 0; bus.in_valid1 = 0; bus.in_ins0 = 0; bus.in_ins1 = 0;
        bus.in_pc = 0; bus.flush = 0; bus.issue_cnt = 0;
        repeat (2) @(negedge clk);
        check_model("reset");
        rst = 1'b1;
        @(negedge clk);
        check_model("post_reset");

        for (int i = 0; i < 17; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(tbl[i].v0, tbl[i].v1, tbl[i].i0, tbl[i].i1, tbl[i].pc, tbl[i].fl, tbl[i].iss, {t, ".model"});
            chk({t, ".count"},    64'(bus.count),    64'(tbl[i].e_cnt));
            chk({t, ".out_cnt"},  64'(bus.out_cnt),  64'(tbl[i].e_oc));
            chk({t, ".eins1"},    64'(bus.eins1),    64'(tbl[i].e1));
            chk({t, ".eins2"},    64'(bus.eins2),    64'(tbl[i].e2));
            chk({t, ".pc_out"},   64'(bus.pc_out),   64'(tbl[i].epc));
            chk({t, ".in_ready"}, 64'(bus.in_ready), 64'(tbl[i].erdy));
        end

        // Asynchronous reset mid-stream at occupancy 5
        step(1,1,32'hB0000000,32'hB0000001,32'h500,0,0,"fill_a");
        step(1,1,32'hB0000002,32'hB0000003,32'h508,0,0,"fill_b");
        step(1,0,32'hB0000004,32'hB0000005,32'h510,0,0,"fill_c");
        chk("pre_rst.count", 64'(bus.count), 64'd5);
        bus.in_valid0 = 0; bus.in_valid1 = 0; bus.issue_cnt = 0;
        #2 rst = 1'b0;
        #1;
        q.delete();
        m_err = 1'b0;
        check_model("async_rst");
        chk("async_rst.eins1", 64'(bus.eins1), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step(0,0,0,0,0,0,0,"after_rst");

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic v0, v1, fl;
            logic [1:0] iss;
            v0  = ($urandom_range(0, 9) < 7);
            v1  = $urandom_range(0, 1);
            fl  = ($urandom_range(0, 24) == 0);
            iss = 2'($urandom_range(0, 3));
            step(v0, v1, $urandom, $urandom, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                 fl, iss, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
